// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB slave that re-issues each transfer as an APB access.
// Adds wait states, maps APB errors/timeouts/bad sizes to AHB ERROR.
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 16,
  parameter int NUM_PSLV    = 4,
  parameter int PSEL_LSB    = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [ADDR_WIDTH-1:0]  HADDR,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic [DATA_WIDTH-1:0]  HWDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [DATA_WIDTH-1:0]  HRDATA,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic [NUM_PSLV-1:0]    PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_WIDTH-1:0]  PWDATA,
  input  logic [DATA_WIDTH-1:0]  PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int IW = (NUM_PSLV > 1) ? $clog2(NUM_PSLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt;
  logic          addr_ok;
  logic          size_bad;
  logic          timeout_hit;

  // A new transfer is accepted only from a state that shows HREADYOUT=1
  assign addr_ok = ((state == IDLE) || (state == ERR2)) &&
                   HSEL && HTRANS[1] && HREADY;
  assign size_bad    = HSIZE > 3'b010;
  assign timeout_hit = cnt == CW'(TIMEOUT - 1);

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ERR2: begin
        if (addr_ok) begin
          if (size_bad)    state_nxt = ERR1;
          else if (HWRITE) state_nxt = WDATA;
          else             state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WDATA:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY)           state_nxt = PSLVERR ? ERR1 : IDLE;
        else if (timeout_hit) state_nxt = ERR1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake and select outputs
  always_comb begin
    HREADYOUT = (state == IDLE) || (state == ERR2);
    HRESP     = (state == ERR1) || (state == ERR2);
    PENABLE   = state == ACCESS;
    PSEL      = '0;
    if ((state == SETUP) || (state == ACCESS)) PSEL[idx_q] = 1'b1;
  end

  // Address-phase capture; held until the next accepted transfer
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      idx_q  <= '0;
    end else if (addr_ok) begin
      PADDR  <= HADDR[PADDR_WIDTH-1:0];
      PWRITE <= HWRITE;
      idx_q  <= HADDR[PSEL_LSB +: IW];
    end
  end

  // Write data arrives in the AHB data phase, one cycle after the address
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)              PWDATA <= '0;
    else if (state == WDATA) PWDATA <= HWDATA;
  end

  // ACCESS-cycle counter used for the hung-peripheral abort
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)               cnt <= '0;
    else if (state == SETUP)  cnt <= '0;
    else if (state == ACCESS) cnt <= cnt + 1'b1;
  end

  // Read data is registered only on a clean APB completion
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HRDATA <= '0;
    end else if ((state == ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
      HRDATA <= PRDATA;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed AHB transfers against a transaction-level
// model that predicts every output on every cycle.
module tb_ahb_apb_bridge;

  localparam int TO = 16;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = 2'b00;
  logic        HREADY = 1'b1;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  ahb_apb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PADDR_WIDTH(16),
    .NUM_PSLV(4), .PSEL_LSB(12), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        hro;
    logic        hresp;
    logic [3:0]  psel;
    logic        pen;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } exp_t;

  exp_t exp_cur;
  bit   exp_on = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   lowrun = 0;
  int   penrun = 0;
  int   last_penrun = 0;
  logic [3:0] last_psel = '0;

  logic [15:0] m_paddr;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [31:0] m_hrdata;
  logic [1:0]  m_idx;
  bit          tail_resp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  function automatic exp_t mk(input logic hro, input logic hresp,
                              input logic sel, input logic pen);
    exp_t e;
    e.hro    = hro;
    e.hresp  = hresp;
    e.psel   = sel ? (4'b0001 << m_idx) : 4'b0000;
    e.pen    = pen;
    e.pwrite = m_pwrite;
    e.paddr  = m_paddr;
    e.pwdata = m_pwdata;
    e.hrdata = m_hrdata;
    return e;
  endfunction

  task automatic model_reset();
    m_paddr   = '0;
    m_pwrite  = 1'b0;
    m_pwdata  = '0;
    m_hrdata  = '0;
    m_idx     = '0;
    tail_resp = 0;
  endtask

  task automatic step(input exp_t e);
    exp_cur = e;
    @(posedge HCLK);
    #1;
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge HCLK);
      if (exp_on) begin
        chk("HREADYOUT", HREADYOUT, exp_cur.hro);
        chk("HRESP", HRESP, exp_cur.hresp);
        chk("PSEL", PSEL, exp_cur.psel);
        chk("PENABLE", PENABLE, exp_cur.pen);
        chk("PWRITE", PWRITE, exp_cur.pwrite);
        chk("PADDR", PADDR, exp_cur.paddr);
        chk("PWDATA", PWDATA, exp_cur.pwdata);
        chk("HRDATA", HRDATA, exp_cur.hrdata);
        if (!HREADYOUT) lowrun++;
        else lowrun = 0;
        if (PENABLE) penrun++;
        else begin
          if (penrun != 0) last_penrun = penrun;
          penrun = 0;
        end
        if (PSEL != 4'b0000) last_psel = PSEL;
      end
    end
  end

  task automatic idle_cycle(input logic sel, input logic [1:0] trans,
                            input logic rdy);
    HSEL = sel;
    HTRANS = trans;
    HREADY = rdy;
    HADDR = 32'h0000_2ABC;
    HWRITE = 1'b1;
    step(mk(1, tail_resp, 0, 0));
    tail_resp = 0;
    HSEL = 0;
    HTRANS = 2'b00;
    HREADY = 1;
    HWRITE = 0;
    HADDR = '0;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits,
                      input logic err, input int rst_at);
    bit to;
    HSEL = 1;
    HTRANS = 2'b10;
    HADDR = addr;
    HWRITE = wr;
    HSIZE = size;
    HREADY = 1;
    step(mk(1, tail_resp, 0, 0));
    tail_resp = 0;
    m_paddr = addr[15:0];
    m_pwrite = wr;
    m_idx = addr[13:12];
    HSEL = 0;
    HTRANS = 2'b00;
    HADDR = '0;
    HWRITE = 0;
    HSIZE = 3'b010;
    HWDATA = wd;
    if (size > 3'b010) begin
      step(mk(0, 1, 0, 0));
      tail_resp = 1;
      return;
    end
    if (wr) begin
      step(mk(0, 0, 0, 0));
      m_pwdata = wd;
    end
    HWDATA = '0;
    step(mk(0, 0, 1, 0));
    to = 0;
    for (int i = 0; i < TO; i++) begin
      if (i == rst_at) begin
        PREADY = 0;
        #1;
        HRESET = 1;
        model_reset();
        exp_cur = mk(1, 0, 0, 0);
        #1;
        chk("async rst HREADYOUT", HREADYOUT, 1);
        chk("async rst HRESP", HRESP, 0);
        chk("async rst PSEL", PSEL, 0);
        chk("async rst PENABLE", PENABLE, 0);
        chk("async rst PADDR", PADDR, 0);
        chk("async rst HRDATA", HRDATA, 0);
        @(posedge HCLK);
        #1;
        HRESET = 0;
        return;
      end
      PREADY = (i == waits);
      PSLVERR = err && (i == waits);
      PRDATA = rd;
      step(mk(0, 0, 1, 1));
      if (i == waits) break;
      if (i == TO - 1) to = 1;
    end
    PREADY = 0;
    PSLVERR = 0;
    if (to || err) begin
      if (to) begin
        PREADY = 1;
        PRDATA = 32'hFFFF_0000;
      end
      step(mk(0, 1, 0, 0));
      tail_resp = 1;
      PREADY = 0;
    end else if (!wr) begin
      m_hrdata = rd;
    end
    PRDATA = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    chk("reset HREADYOUT", HREADYOUT, 1);
    chk("reset HRESP", HRESP, 0);
    chk("reset HRDATA", HRDATA, 0);
    chk("reset PSEL", PSEL, 0);
    chk("reset PENABLE", PENABLE, 0);
    chk("reset PWRITE", PWRITE, 0);
    chk("reset PADDR", PADDR, 0);
    chk("reset PWDATA", PWDATA, 0);
    @(posedge HCLK);
    #1;
    HRESET = 0;
    exp_on = 1;

    idle_cycle(0, 2'b10, 1);
    idle_cycle(1, 2'b00, 1);
    idle_cycle(1, 2'b01, 1);
    idle_cycle(1, 2'b10, 0);

    xfer(0, 32'h0000_1004, 3'b010, 0, 32'hDEAD_BEEF, 0, 0, -1);
    chk("read waits", lowrun, 2);
    chk("read psel", last_psel, 4'b0010);
    chk("read hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("read paddr", PADDR, 16'h1004);

    xfer(1, 32'h0000_3010, 3'b010, 32'h1234_5678, 0, 3, 0, -1);
    chk("write waits", lowrun, 6);
    chk("write psel", last_psel, 4'b1000);
    chk("write pwdata", PWDATA, 32'h1234_5678);
    chk("write pwrite", PWRITE, 1);

    xfer(0, 32'h0000_2008, 3'b010, 0, 32'hBAD0_BAD0, 1, 1, -1);
    chk("slverr waits", lowrun, 4);
    chk("slverr hrdata kept", HRDATA, 32'hDEAD_BEEF);
    chk("slverr err2 hresp", HRESP, 1);

    xfer(0, 32'h0000_0000, 3'b011, 0, 0, 0, 0, -1);
    chk("size err waits", lowrun, 1);
    chk("size err no psel", last_psel, 4'b0100);

    xfer(0, 32'h0000_0000, 3'b010, 0, 32'h0, 1000, 0, -1);
    chk("timeout penable cycles", last_penrun, 16);
    chk("timeout waits", lowrun, 18);

    xfer(0, 32'h0000_0040, 3'b010, 0, 32'hCAFE_F00D, 0, 0, -1);
    chk("post timeout hrdata", HRDATA, 32'hCAFE_F00D);
    chk("post timeout waits", lowrun, 2);

    xfer(0, 32'h0000_1100, 3'b010, 0, 32'hA5A5_A5A5, 0, 0, -1);
    chk("b2b read1 hrdata", HRDATA, 32'hA5A5_A5A5);
    xfer(1, 32'h0000_2200, 3'b010, 32'h0F0F_0F0F, 0, 0, 0, -1);
    chk("b2b write waits", lowrun, 3);
    xfer(0, 32'h0000_3300, 3'b010, 0, 32'h5A5A_5A5A, 2, 0, -1);
    chk("b2b read2 waits", lowrun, 4);
    chk("b2b read2 hrdata", HRDATA, 32'h5A5A_5A5A);

    xfer(0, 32'h0000_1000, 3'b010, 0, 32'h7777_7777, 5, 0, 1);
    idle_cycle(0, 2'b00, 1);
    xfer(0, 32'h0000_0004, 3'b010, 0, 32'h1111_2222, 0, 0, -1);
    chk("post reset hrdata", HRDATA, 32'h1111_2222);
    idle_cycle(0, 2'b00, 1);

    exp_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
